// File: rtl/quad_regfile_pkg.sv
// Shared widths and types for the quad register file and the downstream operand mux.
package regfile_pkg;

    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;
    localparam int ZERO_REG = 0;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] raddr_t;

endpackage

// File: rtl/quad_regfile_if.sv
// Write/read port bundle between the register file and whatever drives it.
interface quad_regfile_if #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              ren;
    logic [ADDR_W-1:0] raddr0;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] regread0;
    logic [DATA_W-1:0] regread1;
    logic              rd_valid;

    modport master (
        output we, waddr, wdata, ren, raddr0, raddr1,
        input  regread0, regread1, rd_valid
    );

    modport slave (
        input  we, waddr, wdata, ren, raddr0, raddr1,
        output regread0, regread1, rd_valid
    );
endinterface

// File: rtl/quad_reg_cell.sv
// Single W-bit register with asynchronous active-high clear and load enable.
module quad_reg_cell #(
    parameter int W = regfile_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/quad_regfile.sv
// Eight-entry register file, R0 hardwired to zero, two registered read ports with write-first bypass.
module quad_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    quad_regfile_if.slave  bus
);

    localparam int REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [REGS];
    logic [DATA_W-1:0] sel0;
    logic [DATA_W-1:0] sel1;
    logic              wr_live;
    logic              valid_q;

    // Writes aimed at the zero register never count as live, for storage or bypass.
    assign wr_live = bus.we && (bus.waddr != ADDR_W'(ZERO_REG));

    assign regs[0] = '0;

    for (genvar i = 1; i < REGS; i++) begin : g_store
        quad_reg_cell #(.W(DATA_W)) u_cell (
            .clk  (clk),
            .rst  (rst),
            .load (wr_live && (bus.waddr == ADDR_W'(i))),
            .d    (bus.wdata),
            .q    (regs[i])
        );
    end

    // Each port independently prefers the in-flight write data over the stale stored word.
    always_comb begin
        sel0 = regs[bus.raddr0];
        sel1 = regs[bus.raddr1];
        if (wr_live && (bus.waddr == bus.raddr0)) begin
            sel0 = bus.wdata;
        end
        if (wr_live && (bus.waddr == bus.raddr1)) begin
            sel1 = bus.wdata;
        end
    end

    quad_reg_cell #(.W(DATA_W)) u_out0 (
        .clk  (clk),
        .rst  (rst),
        .load (bus.ren),
        .d    (sel0),
        .q    (bus.regread0)
    );

    quad_reg_cell #(.W(DATA_W)) u_out1 (
        .clk  (clk),
        .rst  (rst),
        .load (bus.ren),
        .d    (sel1),
        .q    (bus.regread1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.ren;
        end
    end

    assign bus.rd_valid = valid_q;

endmodule

// File: tb/tb_quad_regfile.sv
// Directed-vector bench for quad_regfile with hand-computed expected operands.
module tb_quad_regfile;
    import regfile_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    quad_regfile_if bus ();

    quad_regfile u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] waddr, input logic [3:0] wdata,
                                 input logic ren, input logic [2:0] ra0, input logic [2:0] ra1);
        bus.we     = we;
        bus.waddr  = waddr;
        bus.wdata  = wdata;
        bus.ren    = ren;
        bus.raddr0 = ra0;
        bus.raddr1 = ra1;
    endtask

    // Advance one rising edge and settle just after it, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRead(input string tag, input logic [3:0] e0, input logic [3:0] e1, input logic ev);
        checkOutput({tag, ".r0"}, 8'(bus.regread0), 8'(e0));
        checkOutput({tag, ".r1"}, 8'(bus.regread1), 8'(e1));
        checkOutput({tag, ".vld"}, 8'(bus.rd_valid), 8'(ev));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 3'd0);
        tick();
        tick();
        checkRead("rst_init", 4'h0, 4'h0, 1'b0);
        rst = 1'b0;

        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 3'd0, 4'h0, 1'b1, 3'(i), 3'(8 - i));
            tick();
            checkRead($sformatf("post_rst_r%0d", i), 4'h0, 4'h0, 1'b1);
        end
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 3'd0);
        tick();
        checkOutput("post_rst_vld_drop", 8'(bus.rd_valid), 8'h0);

        // Basic write then read, then hold with ren low.
        applyStimulus(1'b1, 3'd3, 4'hA, 1'b0, 3'd0, 3'd0);
        tick();
        applyStimulus(1'b1, 3'd5, 4'h6, 1'b0, 3'd0, 3'd0);
        tick();
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b1, 3'd3, 3'd5);
        tick();
        checkRead("basic", 4'hA, 4'h6, 1'b1);
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 3'd1, 3'd2);
        tick();
        checkRead("hold1", 4'hA, 4'h6, 1'b0);
        tick();
        checkRead("hold2", 4'hA, 4'h6, 1'b0);

        // R0 protection.
        applyStimulus(1'b1, 3'd0, 4'hF, 1'b0, 3'd0, 3'd0);
        tick();
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b1, 3'd0, 3'd0);
        tick();
        checkRead("r0_prot", 4'h0, 4'h0, 1'b1);

        // Bypass on port 0, then port 1, then both on the same address.
        applyStimulus(1'b1, 3'd2, 4'h1, 1'b0, 3'd0, 3'd0);
        tick();
        applyStimulus(1'b1, 3'd4, 4'h3, 1'b0, 3'd0, 3'd0);
        tick();
        applyStimulus(1'b1, 3'd2, 4'h9, 1'b1, 3'd2, 3'd4);
        tick();
        checkRead("byp0", 4'h9, 4'h3, 1'b1);
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b1, 3'd2, 3'd2);
        tick();
        checkRead("after_byp", 4'h9, 4'h9, 1'b1);
        applyStimulus(1'b1, 3'd4, 4'h5, 1'b1, 3'd2, 3'd4);
        tick();
        checkRead("byp1", 4'h9, 4'h5, 1'b1);
        applyStimulus(1'b1, 3'd7, 4'hB, 1'b1, 3'd7, 3'd7);
        tick();
        checkRead("byp_both", 4'hB, 4'hB, 1'b1);

        // A discarded write to R0 must not bypass.
        applyStimulus(1'b1, 3'd0, 4'hC, 1'b1, 3'd0, 3'd0);
        tick();
        checkRead("byp_zero", 4'h0, 4'h0, 1'b1);
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b1, 3'd3, 3'd4);
        tick();
        checkRead("storage_kept", 4'hA, 4'h5, 1'b1);

        // Reset mid-stream: clears immediately and loses the pending write.
        applyStimulus(1'b1, 3'd6, 4'h7, 1'b0, 3'd0, 3'd0);
        tick();
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b1, 3'd6, 3'd6);
        tick();
        checkRead("r6_pre", 4'h7, 4'h7, 1'b1);
        applyStimulus(1'b1, 3'd6, 4'h2, 1'b1, 3'd6, 3'd6);
        #2;
        rst = 1'b1;
        #1;
        checkRead("rst_async", 4'h0, 4'h0, 1'b0);
        tick();
        checkRead("rst_held", 4'h0, 4'h0, 1'b0);
        #3;
        rst = 1'b0;
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b1, 3'd6, 3'd3);
        tick();
        checkRead("rst_lost", 4'h0, 4'h0, 1'b1);
        applyStimulus(1'b1, 3'd6, 4'hE, 1'b0, 3'd0, 3'd0);
        tick();
        checkOutput("vld_after_write", 8'(bus.rd_valid), 8'h0);
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b1, 3'd1, 3'd6);
        tick();
        checkRead("post_rst_wr", 4'h0, 4'hE, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
